// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing a four-bank main memory between
// the instruction-side (0) and data-side (1) cache controllers. Issues the
// owner's read or write, retries while the target bank is busy, waits out the
// read latency and returns data with a one-cycle done pulse.
module mem_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd0,
  input  logic              wr0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              rd1,
  input  logic              wr1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  input  logic [3:0]        busy,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [1:0]        grant,
  output logic              err
);

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t              state, state_nx;
  logic                owner_q;
  logic                op_wr_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                last_grant_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [DATA_W-1:0]   rdata0_q;
  logic [DATA_W-1:0]   rdata1_q;
  logic                err_q;

  logic                req0, req1, any_req, pick;
  logic [1:0]          bank;
  logic                bank_busy;
  logic [1:0]          owner_hot;

  // Request decode, round-robin pick and bank-busy lookup
  always_comb begin
    req0      = rd0 | wr0;
    req1      = rd1 | wr1;
    any_req   = req0 | req1;
    // Tie goes to whoever did not own the previous grant
    pick      = (req0 && req1) ? ~last_grant_q : req1;
    bank      = addr_q[2:1];
    bank_busy = busy[bank];
    owner_hot = {owner_q, ~owner_q};
  end

  // State register and transaction datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      owner_q      <= 1'b0;
      op_wr_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
      err_q        <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (any_req) begin
            owner_q <= pick;
            // Simultaneous rd and wr is executed as a read
            op_wr_q <= pick ? (wr1 & ~rd1) : (wr0 & ~rd0);
            addr_q  <= pick ? addr1 : addr0;
            wdata_q <= pick ? wdata1 : wdata0;
          end
          if ((rd0 & wr0) | (rd1 & wr1)) err_q <= 1'b1;
        end
        ISSUE: begin
          if (!bank_busy && !op_wr_q) cnt_q <= CNT_W'(MEM_LAT - 1);
        end
        WAIT: begin
          if (cnt_q == '0) begin
            if (owner_q) rdata1_q <= mem_rdata;
            else         rdata0_q <= mem_rdata;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        RESP: last_grant_q <= owner_q;
        default: ;
      endcase
    end
  end

  // Next-state and memory/requester-side outputs
  always_comb begin
    state_nx  = state;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    grant     = 2'b00;
    done0     = 1'b0;
    done1     = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) state_nx = ISSUE;
      end
      ISSUE: begin
        grant     = owner_hot;
        mem_rd    = ~op_wr_q;
        mem_wr    = op_wr_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        if (!bank_busy) state_nx = op_wr_q ? RESP : WAIT;
      end
      WAIT: begin
        grant = owner_hot;
        if (cnt_q == '0) state_nx = RESP;
      end
      RESP: begin
        grant    = owner_hot;
        done0    = ~owner_q;
        done1    = owner_q;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign rdata0 = rdata0_q;
  assign rdata1 = rdata1_q;
  assign err    = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vector table plus hand-written sequences for
// bank-busy retry, asynchronous reset mid-read and the sticky error flag.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd0, wr0, rd1, wr1;
  logic [15:0] addr0, addr1, wdata0, wdata1;
  logic        done0, done1;
  logic [15:0] rdata0, rdata1;
  logic [3:0]  busy;
  logic [15:0] mem_rdata;
  logic        mem_rd, mem_wr;
  logic [15:0] mem_addr, mem_wdata;
  logic [1:0]  grant;
  logic        err;

  int unsigned errors = 0;
  int unsigned checks = 0;

  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(2)) dut (
    .clk(clk), .rst(rst),
    .rd0(rd0), .wr0(wr0), .addr0(addr0), .wdata0(wdata0),
    .rd1(rd1), .wr1(wr1), .addr1(addr1), .wdata1(wdata1),
    .done0(done0), .done1(done1), .rdata0(rdata0), .rdata1(rdata1),
    .busy(busy), .mem_rdata(mem_rdata),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .grant(grant), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  req;     // {rd0, wr0, rd1, wr1}
    logic [15:0] a0, a1, wd0, wd1;
    logic [3:0]  bsy;
    logic [15:0] mrd;
    logic [1:0]  e_strb;  // {mem_rd, mem_wr}
    logic [15:0] e_addr, e_wdata;
    logic [1:0]  e_grant;
    logic [1:0]  e_done;  // {done1, done0}
    logic [15:0] e_rd0, e_rd1;
    logic        e_err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [3:0] req, input logic [15:0] a0, a1, wd0, wd1,
                              input logic [3:0] bsy, input logic [15:0] mrd,
                              input logic [1:0] e_strb, input logic [15:0] e_addr, e_wdata,
                              input logic [1:0] e_grant, e_done,
                              input logic [15:0] e_rd0, e_rd1, input logic e_err);
    vec_t v;
    v.req = req; v.a0 = a0; v.a1 = a1; v.wd0 = wd0; v.wd1 = wd1;
    v.bsy = bsy; v.mrd = mrd; v.e_strb = e_strb; v.e_addr = e_addr;
    v.e_wdata = e_wdata; v.e_grant = e_grant; v.e_done = e_done;
    v.e_rd0 = e_rd0; v.e_rd1 = e_rd1; v.e_err = e_err;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, want);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " mem_rd"}, 32'(mem_rd), 0);
    chk({tag, " mem_wr"}, 32'(mem_wr), 0);
    chk({tag, " mem_addr"}, 32'(mem_addr), 0);
    chk({tag, " mem_wdata"}, 32'(mem_wdata), 0);
    chk({tag, " done"}, 32'({done1, done0}), 0);
    chk({tag, " rdata0"}, 32'(rdata0), 0);
    chk({tag, " rdata1"}, 32'(rdata1), 0);
    chk({tag, " grant"}, 32'(grant), 0);
    chk({tag, " err"}, 32'(err), 0);
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    {rd0, wr0, rd1, wr1} = '0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    busy = '0; mem_rdata = 16'hDEAD;
    repeat (2) cyc();
    chk_all_zero("reset");
    rst = 1'b0;

    // Single read by 0, single write by 1, then contention with alternation
    vecs.push_back(mk(4'b1000, 16'h0010, 0, 0, 0, 0, 16'hDEAD, 2'b00, 0, 0, 2'b00, 2'b00, 0, 0, 0));
    vecs.push_back(mk(4'b1000, 16'h0010, 0, 0, 0, 0, 16'hDEAD, 2'b10, 16'h0010, 0, 2'b01, 2'b00, 0, 0, 0));
    vecs.push_back(mk(4'b1000, 16'h0010, 0, 0, 0, 0, 16'hDEAD, 2'b00, 0, 0, 2'b01, 2'b00, 0, 0, 0));
    vecs.push_back(mk(4'b1000, 16'h0010, 0, 0, 0, 0, 16'hBEEF, 2'b00, 0, 0, 2'b01, 2'b00, 0, 0, 0));
    vecs.push_back(mk(4'b1000, 16'h0010, 0, 0, 0, 0, 16'hDEAD, 2'b00, 0, 0, 2'b01, 2'b01, 16'hBEEF, 0, 0));
    vecs.push_back(mk(4'b0000, 16'h0010, 0, 0, 0, 0, 16'hDEAD, 2'b00, 0, 0, 2'b00, 2'b00, 16'hBEEF, 0, 0));
    vecs.push_back(mk(4'b0001, 0, 16'h0006, 0, 16'h1234, 0, 16'hDEAD, 2'b00, 0, 0, 2'b00, 2'b00, 16'hBEEF, 0, 0));
    vecs.push_back(mk(4'b0001, 0, 16'h0006, 0, 16'h1234, 0, 16'hDEAD, 2'b01, 16'h0006, 16'h1234, 2'b10, 2'b00, 16'hBEEF, 0, 0));
    vecs.push_back(mk(4'b0001, 0, 16'h0006, 0, 16'h1234, 0, 16'hDEAD, 2'b00, 0, 0, 2'b10, 2'b10, 16'hBEEF, 0, 0));
    vecs.push_back(mk(4'b0000, 0, 16'h0006, 0, 16'h1234, 0, 16'hDEAD, 2'b00, 0, 0, 2'b00, 2'b00, 16'hBEEF, 0, 0));
    vecs.push_back(mk(4'b1010, 16'h0020, 16'h0032, 0, 0, 0, 16'hDEAD, 2'b00, 0, 0, 2'b00, 2'b00, 16'hBEEF, 0, 0));
    vecs.push_back(mk(4'b1010, 16'h0020, 16'h0032, 0, 0, 0, 16'hDEAD, 2'b10, 16'h0020, 0, 2'b01, 2'b00, 16'hBEEF, 0, 0));
    vecs.push_back(mk(4'b1010, 16'h0020, 16'h0032, 0, 0, 0, 16'h5A5A, 2'b00, 0, 0, 2'b01, 2'b00, 16'hBEEF, 0, 0));
    vecs.push_back(mk(4'b1010, 16'h0020, 16'h0032, 0, 0, 0, 16'h1111, 2'b00, 0, 0, 2'b01, 2'b00, 16'hBEEF, 0, 0));
    vecs.push_back(mk(4'b1010, 16'h0020, 16'h0032, 0, 0, 0, 16'hDEAD, 2'b00, 0, 0, 2'b01, 2'b01, 16'h1111, 0, 0));
    vecs.push_back(mk(4'b1010, 16'h0020, 16'h0032, 0, 0, 0, 16'hDEAD, 2'b00, 0, 0, 2'b00, 2'b00, 16'h1111, 0, 0));
    vecs.push_back(mk(4'b1010, 16'h0020, 16'h0032, 0, 0, 0, 16'hDEAD, 2'b10, 16'h0032, 0, 2'b10, 2'b00, 16'h1111, 0, 0));
    vecs.push_back(mk(4'b1010, 16'h0020, 16'h0032, 0, 0, 0, 16'h5A5A, 2'b00, 0, 0, 2'b10, 2'b00, 16'h1111, 0, 0));
    vecs.push_back(mk(4'b1010, 16'h0020, 16'h0032, 0, 0, 0, 16'h2222, 2'b00, 0, 0, 2'b10, 2'b00, 16'h1111, 0, 0));
    vecs.push_back(mk(4'b1010, 16'h0020, 16'h0032, 0, 0, 0, 16'hDEAD, 2'b00, 0, 0, 2'b10, 2'b10, 16'h1111, 16'h2222, 0));
    vecs.push_back(mk(4'b1010, 16'h0020, 16'h0032, 0, 0, 0, 16'hDEAD, 2'b00, 0, 0, 2'b00, 2'b00, 16'h1111, 16'h2222, 0));
    vecs.push_back(mk(4'b1000, 16'h0020, 16'h0032, 0, 0, 0, 16'hDEAD, 2'b10, 16'h0020, 0, 2'b01, 2'b00, 16'h1111, 16'h2222, 0));
    vecs.push_back(mk(4'b1000, 16'h0020, 16'h0032, 0, 0, 0, 16'h5A5A, 2'b00, 0, 0, 2'b01, 2'b00, 16'h1111, 16'h2222, 0));
    vecs.push_back(mk(4'b1000, 16'h0020, 16'h0032, 0, 0, 0, 16'h3333, 2'b00, 0, 0, 2'b01, 2'b00, 16'h1111, 16'h2222, 0));
    vecs.push_back(mk(4'b1000, 16'h0020, 16'h0032, 0, 0, 0, 16'hDEAD, 2'b00, 0, 0, 2'b01, 2'b01, 16'h3333, 16'h2222, 0));
    vecs.push_back(mk(4'b0000, 16'h0020, 16'h0032, 0, 0, 0, 16'hDEAD, 2'b00, 0, 0, 2'b00, 2'b00, 16'h3333, 16'h2222, 0));

    foreach (vecs[i]) begin
      cyc();
      {rd0, wr0, rd1, wr1} = vecs[i].req;
      addr0 = vecs[i].a0; addr1 = vecs[i].a1;
      wdata0 = vecs[i].wd0; wdata1 = vecs[i].wd1;
      busy = vecs[i].bsy; mem_rdata = vecs[i].mrd;
      chk($sformatf("v%0d strobes", i), 32'({mem_rd, mem_wr}), 32'(vecs[i].e_strb));
      chk($sformatf("v%0d mem_addr", i), 32'(mem_addr), 32'(vecs[i].e_addr));
      chk($sformatf("v%0d mem_wdata", i), 32'(mem_wdata), 32'(vecs[i].e_wdata));
      chk($sformatf("v%0d grant", i), 32'(grant), 32'(vecs[i].e_grant));
      chk($sformatf("v%0d done", i), 32'({done1, done0}), 32'(vecs[i].e_done));
      chk($sformatf("v%0d rdata0", i), 32'(rdata0), 32'(vecs[i].e_rd0));
      chk($sformatf("v%0d rdata1", i), 32'(rdata1), 32'(vecs[i].e_rd1));
      chk($sformatf("v%0d err", i), 32'(err), 32'(vecs[i].e_err));
    end

    // Bank 2 busy for three ISSUE cycles: write strobe held four cycles
    cyc();
    wr0 = 1'b1; addr0 = 16'h0004; wdata0 = 16'hA5A5; busy = 4'b0100;
    chk("busy idle strobe", 32'(mem_wr), 0);
    for (int k = 1; k <= 3; k++) begin
      cyc();
      chk($sformatf("busy hold%0d mem_wr", k), 32'(mem_wr), 1);
      chk($sformatf("busy hold%0d addr", k), 32'(mem_addr), 32'h0004);
      chk($sformatf("busy hold%0d done0", k), 32'(done0), 0);
    end
    cyc();
    busy = 4'b0000;
    chk("busy accept mem_wr", 32'(mem_wr), 1);
    chk("busy accept wdata", 32'(mem_wdata), 32'hA5A5);
    cyc();
    chk("busy done0", 32'(done0), 1);
    chk("busy resp mem_wr", 32'(mem_wr), 0);
    cyc();
    wr0 = 1'b0;
    chk("busy after done0", 32'(done0), 0);

    // Only an unrelated bank busy: accepted immediately
    cyc();
    wr0 = 1'b1; wdata0 = 16'h5A5A; busy = 4'b0001;
    chk("other bank idle grant", 32'(grant), 0);
    cyc();
    chk("other bank mem_wr", 32'(mem_wr), 1);
    cyc();
    chk("other bank done0", 32'(done0), 1);
    cyc();
    wr0 = 1'b0; busy = 4'b0000;

    // Asynchronous reset during WAIT abandons the read
    cyc();
    rd1 = 1'b1; addr1 = 16'h0008; mem_rdata = 16'hDEAD;
    cyc();
    chk("rstread issue mem_rd", 32'(mem_rd), 1);
    chk("rstread issue grant", 32'(grant), 32'b10);
    cyc();
    chk("rstread wait grant", 32'(grant), 32'b10);
    #2;
    rst = 1'b1; rd1 = 1'b0;
    #1;
    chk_all_zero("async reset");
    cyc();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk($sformatf("post reset done%0d", k), 32'({done1, done0}), 0);
    end
    cyc();
    rd1 = 1'b1; addr1 = 16'h000A;
    cyc();
    chk("new rd1 mem_rd", 32'(mem_rd), 1);
    chk("new rd1 addr", 32'(mem_addr), 32'h000A);
    cyc();
    cyc();
    mem_rdata = 16'h4444;
    cyc();
    mem_rdata = 16'hDEAD;
    chk("new rd1 done1", 32'(done1), 1);
    chk("new rd1 rdata1", 32'(rdata1), 32'h4444);
    cyc();
    rd1 = 1'b0;

    // rd and wr together: performed as a read, err sticky until reset
    cyc();
    rd0 = 1'b1; wr0 = 1'b1; addr0 = 16'h0002;
    chk("protoerr pre err", 32'(err), 0);
    cyc();
    chk("protoerr strobes", 32'({mem_rd, mem_wr}), 32'b10);
    chk("protoerr err", 32'(err), 1);
    cyc();
    cyc();
    mem_rdata = 16'h7777;
    cyc();
    mem_rdata = 16'hDEAD;
    chk("protoerr done0", 32'(done0), 1);
    chk("protoerr rdata0", 32'(rdata0), 32'h7777);
    cyc();
    rd0 = 1'b0; wr0 = 1'b0;
    cyc();
    wr1 = 1'b1; addr1 = 16'h0006; wdata1 = 16'h0001;
    cyc();
    chk("clean write mem_wr", 32'(mem_wr), 1);
    cyc();
    chk("clean write done1", 32'(done1), 1);
    chk("clean write err held", 32'(err), 1);
    cyc();
    wr1 = 1'b0;
    chk("idle err held", 32'(err), 1);
    rst = 1'b1;
    #1;
    chk("err cleared by reset", 32'(err), 0);
    cyc();
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single four-bank main memory between two cache controllers: requester 0 is the instruction side, requester 1 is the data side.
- Grants one requester at a time using round-robin priority and issues that requester's read or write.
- Retries the issue while the target bank is busy, waits out the read latency, then returns data with a one-cycle done pulse to the owner.
- Sits between the cache controllers' mem_rd/mem_wr outputs and the banked memory.

Parameters:
ADDR_W, 16, address width
DATA_W, 16, data width
MEM_LAT, 2, cycles from read acceptance to valid mem_rdata (must be >=1)

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
rd0, wr0  in  1 each  requester 0 read / write request; held high until done0
addr0  in  ADDR_W  requester 0 address
wdata0  in  DATA_W  requester 0 write data
rd1, wr1, addr1, wdata1  in  1/1/ADDR_W/DATA_W  requester 1 equivalents
done0, done1  out  1 each  one-cycle completion pulse to owner
rdata0, rdata1  out  DATA_W each  read data, valid while matching done is high
busy  in  4  per-bank busy from main memory
mem_rdata  in  DATA_W  memory read data
mem_rd, mem_wr  out  1 each  memory read / write strobe
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
grant  out  2  one-hot current owner, 00 when idle
err  out  1  sticky protocol error flag

Behaviour:
- Reset: state=IDLE, last_grant=1, so requester 0 wins the first tie.
  - All outputs 0: mem_rd, mem_wr, mem_addr, mem_wdata, done0/1, rdata0/1, grant, err.
  - Reset mid-transaction abandons it with no done pulse; the memory side is not drained.
- Request and bank rules:
  - reqN = rdN | wrN.
  - If rdN & wrN in IDLE: treat as a read and set err=1 (sticky until reset).
  - Bank = addr[2:1]; the issue is accepted only when busy[bank]==0.
- States:
  - IDLE: no memory strobes, grant=00. If any request is present, pick the owner:
    - only one requesting: that one wins;
    - both requesting: the one not equal to last_grant wins.
    - Latch owner, op, addr, wdata; go to ISSUE.
  - ISSUE: grant=onehot(owner). Drive mem_rd or mem_wr with the latched addr/wdata.
    - If busy[bank]=1: stay in ISSUE with the same outputs (retry, unbounded).
    - Else, write: go to RESP.
    - Else, read: load counter=MEM_LAT-1 and go to WAIT.
  - WAIT: strobes low, grant held. Decrement the counter each cycle.
    - When counter==0: capture mem_rdata into rdata[owner] and go to RESP.
    - WAIT lasts exactly MEM_LAT cycles.
  - RESP: done[owner]=1 for one cycle, grant held, last_grant<=owner, go to IDLE.
    - rdata[owner] holds its value until the next read for that owner; writes leave rdata unchanged.
- Latency from request seen in IDLE (cycle 0), no busy:
  - write: strobe at cycle 1, done at cycle 2;
  - read: strobe at cycle 1, done at cycle MEM_LAT+2.
- The arbiter is idle for one cycle after each RESP; back-to-back grants are therefore spaced at least one IDLE cycle apart.
- Owner drops its request mid-transaction: ignored; the transaction completes and done still pulses.
- The non-owner's requests are not sampled until IDLE. A request arriving during RESP waits.
- Fairness: with both requesters continuously pending, grants strictly alternate.
- mem_rd and mem_wr are never high together, and never high outside ISSUE.

Test Plan:
- Single read: rd0=1, addr0=0x0010, busy=0, mem_rdata=0xBEEF valid 2 cycles after acceptance -> mem_rd high at cycle 1 with mem_addr=0x0010; done0 and rdata0=0xBEEF at cycle 4; done1 never pulses.
- Single write: wr1=1, addr1=0x0006, wdata1=0x1234 -> mem_wr at cycle 1 with mem_addr=0x0006, mem_wdata=0x1234; done1 at cycle 2; grant=10 during cycles 1-2.
- Contention: rd0 and rd1 asserted together from reset -> requester 0 served first, then requester 1; with both held continuously, a third grant goes to 0 (alternation).
- Bank busy: wr0, addr0=0x0004 (bank 2), busy=0100 for 3 cycles -> mem_wr held 4 cycles in ISSUE, accepted when busy clears; busy=0001 instead -> accepted immediately.
- Reset mid-read: assert rst during WAIT -> all outputs 0 at once (asynchronous); no done pulse; a new rd1 after release is served normally.
- Protocol error: rd0=wr0=1 -> performs a read; err=1 and stays 1 through later clean transactions until rst.
